pixel_line_buffer: RTL and testbench

//  Streaming line buffer for KxK convolution windows. Accepts one multi-channel pixel per

---
 rtl/pixel_line_buffer_if.sv | 33 +++
 rtl/pixel_line_buffer.sv | 109 ++++++++++
 tb/tb_pixel_line_buffer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pixel_line_buffer_if.sv
// rtl/pixel_line_buffer_if.sv - pixel stream in / column stream out bundle for the line buffer
interface pixel_line_buffer_if #(
  parameter int DATA_SIZE   = 8,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 1
) ();
  localparam int PW = CHANNELS * DATA_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic                      data_valid;
  logic [PW-1:0]             data_in;
  logic                      flush;
  logic [KERNEL_SIZE*PW-1:0] column_out;
  logic                      column_valid;
  logic [CW-1:0]             col_index;
  logic [RW-1:0]             row_index;
  logic                      frame_done;

  // pixel source / column consumer side
  modport master (
    output data_valid, data_in, flush,
    input  column_out, column_valid, col_index, row_index, frame_done
  );

  // line buffer side
  modport slave (
    input  data_valid, data_in, flush,
    output column_out, column_valid, col_index, row_index, frame_done
  );
endinterface

// File: rtl/pixel_line_buffer.sv
// rtl/pixel_line_buffer.sv - streaming line buffer emitting KERNEL_SIZE-tall pixel columns
module pixel_line_buffer #(
  parameter int DATA_SIZE   = 8,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 1
) (
  input logic           clock,
  input logic           reset_n,
  pixel_line_buffer_if.slave bus
);
  localparam int PW = CHANNELS * DATA_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int NL = KERNEL_SIZE - 1;

  typedef enum logic {FILL, STREAM} state_t;

  state_t state, next_state;

  logic [CW-1:0] col_ptr;
  logic [RW-1:0] row_cnt;

  // L[0] holds the previous row, L[NL-1] the oldest; contents survive reset
  logic [PW-1:0] line_mem [NL][IMG_WIDTH];

  logic                      accept;
  logic                      last_col;
  logic                      last_row;
  logic                      emit;
  logic [KERNEL_SIZE*PW-1:0] column_next;

  // beat qualification, column assembly and FSM next state
  always_comb begin
    accept      = bus.data_valid && !bus.flush;
    last_col    = (col_ptr == CW'(IMG_WIDTH - 1));
    last_row    = (row_cnt == RW'(IMG_HEIGHT - 1));
    emit        = accept && (state == STREAM);
    next_state  = state;
    column_next = '0;
    column_next[(KERNEL_SIZE-1)*PW +: PW] = bus.data_in;
    for (int k = 0; k < NL; k++) begin
      column_next[k*PW +: PW] = line_mem[NL-1-k][col_ptr];
    end
    if (bus.flush) begin
      next_state = FILL;
    end else if (accept) begin
      case (state)
        FILL:   if (last_col && row_cnt == RW'(KERNEL_SIZE - 2)) next_state = STREAM;
        STREAM: if (last_col && last_row) next_state = FILL;
        default: next_state = FILL;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= next_state;
  end

  // shift the column at col_ptr down one line memory on every accepted beat
  always_ff @(posedge clock) begin
    if (accept) begin
      line_mem[0][col_ptr] <= bus.data_in;
      for (int i = 1; i < NL; i++) begin
        line_mem[i][col_ptr] <= line_mem[i-1][col_ptr];
      end
    end
  end

  // raster position counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_ptr <= '0;
      row_cnt <= '0;
    end else if (bus.flush) begin
      col_ptr <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_ptr <= '0;
        row_cnt <= last_row ? '0 : row_cnt + RW'(1);
      end else begin
        col_ptr <= col_ptr + CW'(1);
      end
    end
  end

  // registered column output; data and indices hold between emitted columns
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.column_out   <= '0;
      bus.column_valid <= 1'b0;
      bus.col_index    <= '0;
      bus.row_index    <= '0;
      bus.frame_done   <= 1'b0;
    end else begin
      bus.column_valid <= emit;
      bus.frame_done   <= emit && last_col && last_row;
      if (emit) begin
        bus.column_out <= column_next;
        bus.col_index  <= col_ptr;
        bus.row_index  <= row_cnt;
      end
    end
  end
endmodule

// File: tb/tb_pixel_line_buffer.sv
// tb/tb_pixel_line_buffer.sv - randomized self-checking bench against a frame-array reference model
module tb_pixel_line_buffer;
  localparam int W = 4;
  localparam int H = 4;
  localparam int K = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pixel_line_buffer_if #(.DATA_SIZE(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K), .CHANNELS(1)) ifc ();
  pixel_line_buffer_if #(.DATA_SIZE(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K), .CHANNELS(2)) ifc2 ();

  pixel_line_buffer #(.DATA_SIZE(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K), .CHANNELS(1)) dut (
    .clock(clock), .reset_n(reset_n), .bus(ifc.slave));
  pixel_line_buffer #(.DATA_SIZE(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K), .CHANNELS(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(ifc2.slave));

  int checks = 0;
  int errors = 0;

  // reference model: current frame as a 2-D array plus raster position
  logic [7:0]  pix [H][W];
  int          r, c;
  logic        exp_v, exp_fd;
  logic [23:0] exp_col;
  logic [47:0] exp_col2;
  int          exp_ci, exp_ri;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    r = 0; c = 0;
    exp_v = 0; exp_fd = 0; exp_col = '0; exp_col2 = '0; exp_ci = 0; exp_ri = 0;
  endtask

  task automatic compare_all();
    check("column_valid", 64'(ifc.column_valid), 64'(exp_v));
    check("frame_done",   64'(ifc.frame_done),   64'(exp_fd));
    check("column_out",   64'(ifc.column_out),   64'(exp_col));
    check("col_index",    64'(ifc.col_index),    64'(exp_ci));
    check("row_index",    64'(ifc.row_index),    64'(exp_ri));
    check("ch2_valid",    64'(ifc2.column_valid), 64'(exp_v));
    check("ch2_column",   64'(ifc2.column_out),   64'(exp_col2));
  endtask

  // one clock cycle of stimulus; the model predicts the registered outputs
  task automatic beat(input logic v, input logic [7:0] d, input logic f);
    logic [7:0] d1;
    d1 = d + 8'd100;
    ifc.data_valid  = v; ifc.data_in  = d;        ifc.flush  = f;
    ifc2.data_valid = v; ifc2.data_in = {d1, d};  ifc2.flush = f;
    @(posedge clock); #1;
    if (f) begin
      r = 0; c = 0; exp_v = 0; exp_fd = 0;
    end else if (v) begin
      pix[r][c] = d;
      if (r >= K - 1) begin
        exp_v    = 1;
        exp_fd   = (r == H - 1) && (c == W - 1);
        exp_col  = {pix[r][c], pix[r-1][c], pix[r-2][c]};
        exp_col2 = {pix[r][c] + 8'd100, pix[r][c], pix[r-1][c] + 8'd100, pix[r-1][c],
                    pix[r-2][c] + 8'd100, pix[r-2][c]};
        exp_ci   = c;
        exp_ri   = r;
      end else begin
        exp_v = 0; exp_fd = 0;
      end
      c++;
      if (c == W) begin
        c = 0;
        r = (r == H - 1) ? 0 : r + 1;
      end
    end else begin
      exp_v = 0; exp_fd = 0;
    end
    compare_all();
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_column_valid", 64'(ifc.column_valid), 64'd0);
    check("rst_column_out",   64'(ifc.column_out),   64'd0);
    check("rst_indices",      64'({ifc.col_index, ifc.row_index}), 64'd0);
    check("rst_frame_done",   64'(ifc.frame_done),   64'd0);
    ifc.data_valid = 0; ifc2.data_valid = 0; ifc.flush = 0; ifc2.flush = 0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.data_valid = 0; ifc.data_in = '0; ifc.flush = 0;
    ifc2.data_valid = 0; ifc2.data_in = '0; ifc2.flush = 0;
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) pix[i][j] = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // some traffic, then an asynchronous reset in the middle of a frame
    for (int n = 0; n < 13; n++) beat(1'b1, 8'($urandom), 1'b0);
    async_reset();

    // directed frame: pixel n = n
    for (int n = 0; n < 16; n++) begin
      beat(1'b1, 8'(n), 1'b0);
      if (n == 7) check("t1_no_column", 64'(ifc.column_valid), 64'd0);
      if (n == 8) begin
        check("t2_column",  64'(ifc.column_out), 64'h080400);
        check("t2_indices", 64'({ifc.column_valid, ifc.col_index, ifc.row_index}), 64'b1_00_10);
        check("t6_slices",  64'({ifc2.column_out[40 +: 8], ifc2.column_out[32 +: 8],
                                 ifc2.column_out[8 +: 8],  ifc2.column_out[0 +: 8]}),
                            64'({8'd108, 8'd8, 8'd100, 8'd0}));
      end
      if (n == 15) check("t3_frame_done", 64'({ifc.frame_done, ifc.column_out}), 64'h1_0F0B07);
    end
    for (int n = 16; n < 32; n++) beat(1'b1, 8'(n), 1'b0);

    // gaps on every other cycle across a full frame
    for (int n = 0; n < 16; n++) begin
      beat(1'b1, 8'(n), 1'b0);
      beat(1'b0, 8'($urandom), 1'b0);
    end

    // flush with pixel 10 drops it and restarts the frame
    for (int n = 0; n < 10; n++) beat(1'b1, 8'(n), 1'b0);
    beat(1'b1, 8'd10, 1'b1);
    for (int n = 0; n < 9; n++) beat(1'b1, 8'(n + 11), 1'b0);
    check("t5_first_after_flush", 64'({ifc.column_valid, ifc.row_index, ifc.col_index}), 64'b1_10_00);

    // randomized traffic with gaps and occasional flushes
    for (int n = 0; n < 600; n++) begin
      beat(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 49) == 0));
      if (n == 300) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
